// File: rtl/sram_loader_bridge.sv
// sram_loader_bridge
//   Front-end for a single-port byte-write SRAM. Two requesters share the port:
//   a CPU native memory interface and a sequential byte-stream firmware loader.
//   The loader has fixed priority over the CPU.
//
// Handshakes:
//   cpu_valid is raised with a stable request and held until cpu_ready. cpu_ready
//   is a one-cycle completion pulse, and cpu_rdata is meaningful only while it is
//   high. ld_valid offers one byte. ld_ready is combinational and marks the cycle
//   in which that byte is accepted. A byte counts as transferred on a clock edge
//   where ld_valid and ld_ready are both high.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cpu_valid/ready/addr/wdata/wstrb/rdata   CPU request/response (wstrb==0: read)
//   ld_start                      clears the byte pointer and ld_overflow
//   ld_valid/ready/byte           loader byte stream
//   ld_count                      byte pointer value
//   ld_overflow                   sticky: pointer wrapped
//   sram_addr/din/we/en           registered SRAM controls
//   sram_dout                     SRAM registered read data
//   fsm_state                     debug view of the controller state
module sram_loader_bridge #(
  parameter int NB_COL     = 4,
  parameter int COL_WIDTH  = 8,
  parameter int ADDR_WIDTH = 13
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cpu_valid,
  output logic                          cpu_ready,
  input  logic [31:0]                   cpu_addr,
  input  logic [NB_COL*COL_WIDTH-1:0]   cpu_wdata,
  input  logic [NB_COL-1:0]             cpu_wstrb,
  output logic [NB_COL*COL_WIDTH-1:0]   cpu_rdata,
  input  logic                          ld_start,
  input  logic                          ld_valid,
  output logic                          ld_ready,
  input  logic [COL_WIDTH-1:0]          ld_byte,
  output logic [ADDR_WIDTH+1:0]         ld_count,
  output logic                          ld_overflow,
  output logic [ADDR_WIDTH-1:0]         sram_addr,
  output logic [NB_COL*COL_WIDTH-1:0]   sram_din,
  output logic [NB_COL-1:0]             sram_we,
  output logic                          sram_en,
  input  logic [NB_COL*COL_WIDTH-1:0]   sram_dout,
  output logic [2:0]                    fsm_state
);

  localparam int DW = NB_COL * COL_WIDTH;
  localparam int PW = ADDR_WIDTH + 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LD_WR  = 3'd1,
    S_ACCESS = 3'd2,
    S_RESP   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [PW-1:0]         ptr;
  logic [PW-1:0]         ptr_base;
  logic [PW-1:0]         ptr_d;
  logic                  ovf_d;
  logic                  ld_accept;
  logic                  cpu_go;
  logic                  is_rd;

  logic                  en_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [NB_COL-1:0]     we_d;
  logic [DW-1:0]         din_d;
  logic                  ready_d;
  logic [DW-1:0]         rdata_d;
  logic                  rd_d;

  // Address bits outside the word index alias and are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_addr[31:ADDR_WIDTH+2], cpu_addr[1:0]};

  assign ld_accept = (state == S_IDLE) && ld_valid;
  assign ld_ready  = ld_accept;
  assign cpu_go    = (state == S_IDLE) && !ld_valid && cpu_valid && !cpu_ready;
  // A coincident ld_start restarts the stream at byte 0 in the same cycle.
  assign ptr_base  = ld_start ? '0 : ptr;
  assign ld_count  = ptr;
  assign fsm_state = state;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (ld_accept)   state_nxt = S_LD_WR;
        else if (cpu_go) state_nxt = S_ACCESS;
      end
      S_LD_WR:  state_nxt = S_IDLE;
      S_ACCESS: state_nxt = S_RESP;
      S_RESP:   state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered SRAM and CPU outputs
  always_comb begin
    en_d    = sram_en;
    addr_d  = sram_addr;
    we_d    = sram_we;
    din_d   = sram_din;
    ready_d = cpu_ready;
    rdata_d = cpu_rdata;
    rd_d    = is_rd;
    case (state)
      S_IDLE: begin
        if (ld_accept) begin
          en_d   = 1'b1;
          addr_d = ptr_base[PW-1:2];
          we_d   = NB_COL'(1) << ptr_base[1:0];
          din_d  = {NB_COL{ld_byte}};
        end else if (cpu_go) begin
          en_d   = 1'b1;
          addr_d = cpu_addr[ADDR_WIDTH+1:2];
          we_d   = cpu_wstrb;
          din_d  = cpu_wdata;
          rd_d   = (cpu_wstrb == '0);
        end
      end
      S_LD_WR, S_ACCESS: begin
        en_d = 1'b0;
        we_d = '0;
      end
      S_RESP: begin
        // sram_dout holds the word registered by the SRAM on the ACCESS edge.
        rdata_d = is_rd ? sram_dout : '0;
        ready_d = 1'b1;
      end
      S_DONE: begin
        ready_d = 1'b0;
        rdata_d = '0;
      end
      default: begin
        en_d = 1'b0;
        we_d = '0;
      end
    endcase
  end

  // Pointer and sticky overflow
  always_comb begin
    ptr_d = ptr_base;
    ovf_d = ld_start ? 1'b0 : ld_overflow;
    if (ld_accept) begin
      ptr_d = ptr_base + 1'b1;
      if (!ld_start && (&ptr)) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sram_en     <= 1'b0;
      sram_addr   <= '0;
      sram_we     <= '0;
      sram_din    <= '0;
      cpu_ready   <= 1'b0;
      cpu_rdata   <= '0;
      is_rd       <= 1'b0;
      ptr         <= '0;
      ld_overflow <= 1'b0;
    end else begin
      sram_en     <= en_d;
      sram_addr   <= addr_d;
      sram_we     <= we_d;
      sram_din    <= din_d;
      cpu_ready   <= ready_d;
      cpu_rdata   <= rdata_d;
      is_rd       <= rd_d;
      ptr         <= ptr_d;
      ld_overflow <= ovf_d;
    end
  end

endmodule

// File: tb/tb_sram_loader_bridge.sv
module tb_sram_loader_bridge;

  localparam int NB_COL = 4;
  localparam int COL_WIDTH = 8;
  localparam int ADDR_WIDTH = 13;
  localparam int DW = 32;
  localparam int NBYTES = 1 << (ADDR_WIDTH + 2);
  localparam int NWORDS = 1 << ADDR_WIDTH;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  cpu_valid = 1'b0;
  logic                  cpu_ready;
  logic [31:0]           cpu_addr = '0;
  logic [DW-1:0]         cpu_wdata = '0;
  logic [NB_COL-1:0]     cpu_wstrb = '0;
  logic [DW-1:0]         cpu_rdata;
  logic                  ld_start = 1'b0;
  logic                  ld_valid = 1'b0;
  logic                  ld_ready;
  logic [COL_WIDTH-1:0]  ld_byte = '0;
  logic [ADDR_WIDTH+1:0] ld_count;
  logic                  ld_overflow;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [DW-1:0]         sram_din;
  logic [NB_COL-1:0]     sram_we;
  logic                  sram_en;
  logic [DW-1:0]         sram_dout = '0;
  logic [2:0]            fsm_state;

  int n_tests = 0;
  int n_fail = 0;

  // Reference model: flat byte memory plus the loader pointer.
  logic [7:0]  ref_mem [NBYTES];
  int          ref_ptr = 0;
  bit          ref_ovf = 0;
  logic [31:0] exp_q [$];

  // SRAM macro model: byte-write, 1-cycle registered read, zero when idle.
  logic [DW-1:0] sram_mem [NWORDS];

  sram_loader_bridge #(.NB_COL(NB_COL), .COL_WIDTH(COL_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk(clk), .rst(rst),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_rdata(cpu_rdata),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_byte(ld_byte),
    .ld_count(ld_count), .ld_overflow(ld_overflow),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_we(sram_we), .sram_en(sram_en),
    .sram_dout(sram_dout), .fsm_state(fsm_state)
  );

  // Clock / SRAM
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sram_en) begin
      for (int i = 0; i < NB_COL; i++)
        if (sram_we[i]) sram_mem[sram_addr][8*i +: 8] <= sram_din[8*i +: 8];
      sram_dout <= sram_mem[sram_addr];
    end else begin
      sram_dout <= '0;
    end
  end

  // Reference model helpers
  function automatic int word_of(input logic [31:0] addr);
    return int'((addr >> 2) & (NWORDS - 1));
  endfunction

  function automatic logic [31:0] model_read(input int word);
    return {ref_mem[4*word+3], ref_mem[4*word+2], ref_mem[4*word+1], ref_mem[4*word]};
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
    int w;
    w = word_of(addr);
    for (int i = 0; i < 4; i++)
      if (wstrb[i]) ref_mem[4*w+i] = wdata[8*i +: 8];
  endtask

  task automatic model_load(input logic [7:0] b);
    ref_mem[ref_ptr] = b;
    if (ref_ptr == NBYTES - 1) begin
      ref_ptr = 0;
      ref_ovf = 1;
    end else begin
      ref_ptr = ref_ptr + 1;
    end
  endtask

  // Driver tasks
  task automatic cpu_access(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                            output logic [31:0] rdata, output int lat);
    @(negedge clk);
    cpu_valid = 1'b1; cpu_addr = addr; cpu_wdata = wdata; cpu_wstrb = wstrb;
    lat = -1; rdata = '0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (cpu_ready) begin
        lat = i; rdata = cpu_rdata;
        break;
      end
    end
    cpu_valid = 1'b0; cpu_wstrb = '0;
  endtask

  task automatic ld_push(input logic [7:0] b, input bit start, output bit ok,
                         output logic [3:0] we, output logic [12:0] addr, output logic en,
                         output logic [31:0] din);
    @(negedge clk);
    ld_valid = 1'b1; ld_byte = b; ld_start = start;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (ld_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    we = sram_we; addr = sram_addr; en = sram_en; din = sram_din;
    ld_valid = 1'b0; ld_start = 1'b0;
  endtask

  // Tests
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++; if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL rst_cpu_ready: got %b expected 0", cpu_ready); end
    n_tests++; if (cpu_rdata !== '0) begin n_fail++; $display("FAIL rst_cpu_rdata: got %h expected 0", cpu_rdata); end
    n_tests++; if (sram_en !== 1'b0) begin n_fail++; $display("FAIL rst_sram_en: got %b expected 0", sram_en); end
    n_tests++; if (sram_we !== '0) begin n_fail++; $display("FAIL rst_sram_we: got %h expected 0", sram_we); end
    n_tests++; if (sram_addr !== '0) begin n_fail++; $display("FAIL rst_sram_addr: got %h expected 0", sram_addr); end
    n_tests++; if (sram_din !== '0) begin n_fail++; $display("FAIL rst_sram_din: got %h expected 0", sram_din); end
    n_tests++; if (ld_count !== '0) begin n_fail++; $display("FAIL rst_ld_count: got %0d expected 0", ld_count); end
    n_tests++; if (ld_overflow !== 1'b0) begin n_fail++; $display("FAIL rst_ld_overflow: got %b expected 0", ld_overflow); end
    n_tests++; if (fsm_state !== 3'd0) begin n_fail++; $display("FAIL rst_state: got %0d expected IDLE(0)", fsm_state); end
    rst = 1'b0;
    ref_ptr = 0; ref_ovf = 0;
  endtask

  task automatic test_cpu_basic();
    logic [31:0] r;
    int lat;
    cpu_access(32'h10, 32'hDEADBEEF, 4'hF, r, lat);
    model_write(32'h10, 32'hDEADBEEF, 4'hF);
    n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL wr_latency: got %0d expected 3", lat); end
    n_tests++; if (r !== 32'h0) begin n_fail++; $display("FAIL wr_rdata: got %h expected 0", r); end
    @(negedge clk);
    n_tests++; if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL ready_width: got %b expected 0", cpu_ready); end
    cpu_access(32'h10, 32'h0, 4'h0, r, lat);
    exp_q.push_back(model_read(word_of(32'h10)));
    n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL rd_latency: got %0d expected 3", lat); end
    n_tests++; if (r !== exp_q[0]) begin n_fail++; $display("FAIL rd_full: got %h expected %h", r, exp_q[0]); end
    void'(exp_q.pop_front());
    cpu_access(32'h10, 32'h0000AA00, 4'h2, r, lat);
    model_write(32'h10, 32'h0000AA00, 4'h2);
    cpu_access(32'h10, 32'h0, 4'h0, r, lat);
    exp_q.push_back(model_read(word_of(32'h10)));
    n_tests++; if (r !== exp_q[0]) begin n_fail++; $display("FAIL rd_partial: got %h expected %h", r, exp_q[0]); end
    void'(exp_q.pop_front());
  endtask

  task automatic test_loader();
    logic [7:0] bytes [5];
    logic [3:0] we; logic [12:0] addr; logic en; logic [31:0] din, r;
    bit ok; int p, lat;
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44; bytes[4] = 8'h55;
    @(negedge clk); ld_start = 1'b1;
    @(negedge clk); ld_start = 1'b0;
    ref_ptr = 0; ref_ovf = 0;
    for (int i = 0; i < 5; i++) begin
      p = ref_ptr;
      ld_push(bytes[i], 1'b0, ok, we, addr, en, din);
      model_load(bytes[i]);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL ld_ready_timeout: byte %0d not accepted", i); end
      n_tests++; if (we !== 4'(1 << (p % 4))) begin n_fail++; $display("FAIL ld_we[%0d]: got %h expected %h", i, we, 4'(1 << (p % 4))); end
      n_tests++; if (addr !== 13'(p / 4)) begin n_fail++; $display("FAIL ld_addr[%0d]: got %0d expected %0d", i, addr, p / 4); end
      n_tests++; if (din !== {4{bytes[i]}}) begin n_fail++; $display("FAIL ld_din[%0d]: got %h expected %h", i, din, {4{bytes[i]}}); end
    end
    n_tests++; if (ld_count !== 15'(ref_ptr)) begin n_fail++; $display("FAIL ld_count5: got %0d expected %0d", ld_count, ref_ptr); end
    cpu_access(32'h0, 32'h0, 4'h0, r, lat);
    exp_q.push_back(model_read(0));
    n_tests++; if (r !== exp_q[0]) begin n_fail++; $display("FAIL ld_readback: got %h expected %h", r, exp_q[0]); end
    void'(exp_q.pop_front());
  endtask

  task automatic test_contention();
    logic [7:0] b; int p, lat; bit ld_rdy;
    logic [3:0] we0; logic [12:0] addr0; logic en0;
    logic [12:0] addr3; logic en3;
    b = 8'($urandom);
    p = ref_ptr;
    @(negedge clk);
    cpu_valid = 1'b1; cpu_addr = 32'h20; cpu_wdata = '0; cpu_wstrb = '0;
    ld_valid = 1'b1; ld_byte = b;
    #1 ld_rdy = ld_ready;
    model_load(b);
    @(negedge clk);
    ld_valid = 1'b0;
    we0 = sram_we; addr0 = sram_addr; en0 = sram_en;
    lat = -1; addr3 = '0; en3 = 1'b0;
    for (int i = 2; i <= 40; i++) begin
      @(negedge clk);
      if (i == 3) begin addr3 = sram_addr; en3 = sram_en; end
      if (cpu_ready) begin lat = i; break; end
    end
    exp_q.push_back(model_read(word_of(32'h20)));
    n_tests++; if (ld_rdy !== 1'b1) begin n_fail++; $display("FAIL cont_ld_ready: got %b expected 1", ld_rdy); end
    n_tests++; if (en0 !== 1'b1 || we0 !== 4'(1 << (p % 4)) || addr0 !== 13'(p / 4))
      begin n_fail++; $display("FAIL cont_ld_first: got en=%b we=%h addr=%0d expected en=1 we=%h addr=%0d", en0, we0, addr0, 4'(1 << (p % 4)), p / 4); end
    n_tests++; if (en3 !== 1'b1 || addr3 !== 13'(word_of(32'h20)))
      begin n_fail++; $display("FAIL cont_cpu_issue: got en=%b addr=%0d expected en=1 addr=%0d", en3, addr3, word_of(32'h20)); end
    n_tests++; if (lat !== 5) begin n_fail++; $display("FAIL cont_latency: got %0d expected 5", lat); end
    n_tests++; if (cpu_rdata !== exp_q[0]) begin n_fail++; $display("FAIL cont_rdata: got %h expected %h", cpu_rdata, exp_q[0]); end
    void'(exp_q.pop_front());
    cpu_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    int gap;
    bit seen;
    @(negedge clk);
    cpu_valid = 1'b1; cpu_addr = 32'h0; cpu_wstrb = '0;
    exp_q.push_back(model_read(0));
    exp_q.push_back(model_read(word_of(32'h10)));
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cpu_ready) begin seen = 1; break; end
    end
    n_tests++; if (!seen || cpu_rdata !== exp_q[0]) begin n_fail++; $display("FAIL b2b_first: got %h ready=%b expected %h", cpu_rdata, seen, exp_q[0]); end
    void'(exp_q.pop_front());
    cpu_addr = 32'h10;
    gap = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (cpu_ready) begin gap = i; break; end
    end
    n_tests++; if (gap !== 4) begin n_fail++; $display("FAIL b2b_gap: got %0d expected 4", gap); end
    n_tests++; if (cpu_rdata !== exp_q[0]) begin n_fail++; $display("FAIL b2b_second: got %h expected %h", cpu_rdata, exp_q[0]); end
    void'(exp_q.pop_front());
    cpu_valid = 1'b0;
  endtask

  task automatic test_random_cpu();
    logic [31:0] addr, wdata, r, expv;
    logic [3:0] wstrb;
    int lat;
    for (int i = 0; i < 40; i++) begin
      addr  = ($urandom & 32'hFFFF_8000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      wdata = $urandom;
      wstrb = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      expv  = (wstrb == 4'h0) ? model_read(word_of(addr)) : 32'h0;
      cpu_access(addr, wdata, wstrb, r, lat);
      if (wstrb != 4'h0) model_write(addr, wdata, wstrb);
      n_tests++; if (lat !== 3 || r !== expv)
        begin n_fail++; $display("FAIL rand_cpu[%0d]: got rdata=%h lat=%0d expected rdata=%h lat=3 (addr=%h wstrb=%h)", i, r, lat, expv, addr, wstrb); end
    end
  endtask

  task automatic test_wrap_restart();
    logic [3:0] we; logic [12:0] addr; logic en; logic [31:0] din, r;
    logic [7:0] b;
    bit ok; int n, guard, lat, w;
    @(negedge clk); ld_start = 1'b1;
    @(negedge clk); ld_start = 1'b0;
    ref_ptr = 0; ref_ovf = 0;
    // Stream bytes until the pointer reaches all-ones.
    n = 0; guard = 0;
    ld_valid = 1'b1;
    while (n < NBYTES - 1 && guard < 3 * NBYTES) begin
      #1;
      if (ld_ready) begin
        b = 8'($urandom); ld_byte = b; model_load(b); n++;
      end
      @(negedge clk);
      guard++;
    end
    ld_valid = 1'b0;
    n_tests++; if (n != NBYTES - 1) begin n_fail++; $display("FAIL stream_timeout: got %0d bytes expected %0d", n, NBYTES - 1); end
    n_tests++; if (ld_count !== 15'(ref_ptr) || ld_overflow !== ref_ovf)
      begin n_fail++; $display("FAIL pre_wrap: got count=%0d ovf=%b expected count=%0d ovf=%b", ld_count, ld_overflow, ref_ptr, ref_ovf); end
    b = 8'($urandom);
    ld_push(b, 1'b0, ok, we, addr, en, din);
    model_load(b);
    n_tests++; if (!ok || we !== 4'h8 || addr !== 13'h1FFF)
      begin n_fail++; $display("FAIL wrap_write: got ok=%b we=%h addr=%h expected ok=1 we=8 addr=1fff", ok, we, addr); end
    n_tests++; if (ld_overflow !== 1'b1 || ld_count !== 15'(ref_ptr))
      begin n_fail++; $display("FAIL wrap_flags: got ovf=%b count=%0d expected ovf=1 count=%0d", ld_overflow, ld_count, ref_ptr); end
    b = 8'($urandom);
    ld_push(b, 1'b0, ok, we, addr, en, din);
    model_load(b);
    n_tests++; if (ld_overflow !== 1'b1 || ld_count !== 15'(ref_ptr))
      begin n_fail++; $display("FAIL ovf_sticky: got ovf=%b count=%0d expected ovf=1 count=%0d", ld_overflow, ld_count, ref_ptr); end
    // Restart with ld_start coincident with a byte.
    b = 8'($urandom);
    ld_push(b, 1'b1, ok, we, addr, en, din);
    ref_ptr = 0; ref_ovf = 0;
    model_load(b);
    n_tests++; if (!ok || we !== 4'h1 || addr !== 13'h0 || din[7:0] !== b)
      begin n_fail++; $display("FAIL restart_write: got we=%h addr=%h din=%h expected we=1 addr=0 byte=%h", we, addr, din, b); end
    n_tests++; if (ld_overflow !== 1'b0 || ld_count !== 15'd1)
      begin n_fail++; $display("FAIL restart_flags: got ovf=%b count=%0d expected ovf=0 count=1", ld_overflow, ld_count); end
    for (int i = 0; i < 4; i++) begin
      w = (i == 0) ? 0 : (i == 1) ? NWORDS - 1 : $urandom_range(0, NWORDS - 1);
      cpu_access(32'(w) << 2, 32'h0, 4'h0, r, lat);
      exp_q.push_back(model_read(w));
      n_tests++; if (r !== exp_q[0]) begin n_fail++; $display("FAIL stream_readback[%0d]: got %h expected %h", w, r, exp_q[0]); end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_reset_in_access();
    logic [31:0] r;
    int lat;
    bit saw_ready;
    @(negedge clk);
    cpu_valid = 1'b1; cpu_addr = 32'h10; cpu_wstrb = '0;
    @(negedge clk);
    n_tests++; if (sram_en !== 1'b1) begin n_fail++; $display("FAIL acc_issued: got en=%b expected 1", sram_en); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; cpu_valid = 1'b0;
    ref_ptr = 0; ref_ovf = 0;
    n_tests++; if (cpu_ready !== 1'b0 || sram_en !== 1'b0)
      begin n_fail++; $display("FAIL rst_acc_out: got ready=%b en=%b expected 0 0", cpu_ready, sram_en); end
    n_tests++; if (fsm_state !== 3'd0) begin n_fail++; $display("FAIL rst_acc_state: got %0d expected IDLE(0)", fsm_state); end
    n_tests++; if (ld_count !== '0 || ld_overflow !== 1'b0)
      begin n_fail++; $display("FAIL rst_acc_ptr: got count=%0d ovf=%b expected 0 0", ld_count, ld_overflow); end
    saw_ready = 0;
    repeat (6) begin
      @(negedge clk);
      if (cpu_ready) saw_ready = 1;
    end
    n_tests++; if (saw_ready !== 1'b0) begin n_fail++; $display("FAIL rst_acc_noready: got %b expected 0", saw_ready); end
    cpu_access(32'h10, 32'h0, 4'h0, r, lat);
    exp_q.push_back(model_read(word_of(32'h10)));
    n_tests++; if (lat !== 3 || r !== exp_q[0]) begin n_fail++; $display("FAIL reissue: got %h lat=%0d expected %h lat=3", r, lat, exp_q[0]); end
    void'(exp_q.pop_front());
  endtask

  initial begin
    for (int i = 0; i < NWORDS; i++) sram_mem[i] = '0;
    for (int i = 0; i < NBYTES; i++) ref_mem[i] = '0;
    test_reset();
    test_cpu_basic();
    test_loader();
    test_contention();
    test_back_to_back();
    test_random_cpu();
    test_wrap_restart();
    test_reset_in_access();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
